// File: rtl/pll_lock_sequencer_pkg.sv
// pll_lock_sequencer_pkg
//   Shared types and constants for the PLL lock sequencer.
//   - state_t : sequencer states
//   - RETRY_W : width of the retry counter output
//   - max3()  : largest of three cycle parameters, used to size the shared counter
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam int RETRY_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer for asynchronous level inputs.
//   Ports:
//     i_clk   destination clock
//     i_rst_n asynchronous active-low reset, clears both stages to 0
//     i_d     asynchronous input
//     o_q     synchronized output (two destination-clock cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up the system PLL from the free-running reference clock: holds the
//   PLL in reset, waits for LOCK with a timeout and bounded retries, demands a
//   stable LOCK window, then releases the downstream active-low system reset.
//   Ports:
//     i_clk          reference clock (free-running, not the PLL output)
//     i_rst_n        asynchronous active-low block reset
//     i_pll_lock     raw PLL LOCK, asynchronous to i_clk
//     i_restart      single-cycle request to re-run the sequence from HOLD
//     o_pll_resetb   PLL RESETB (active-low)
//     o_sys_reset_n  active-low reset to the PLL clock domain
//     o_pll_ready    high only in RUN
//     o_fault        high only in FAULT
//     o_retry_count  failed attempts since reset/restart, saturates at MAX_RETRIES
//   Build option:
//     PLL_SEQ_LOCK_MONITOR_EN  when defined, losing lock in RUN counts as a
//                              failed attempt and returns to HOLD (or FAULT).
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pll_lock,
  input  logic               i_restart,
  output logic               o_pll_resetb,
  output logic               o_sys_reset_n,
  output logic               o_pll_ready,
  output logic               o_fault,
  output logic [RETRY_W-1:0] o_retry_count
);

  localparam int CNT_MAX = max3(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  // Counter load for a state: it is a down-counter that expires at zero, so a
  // state lasting N cycles is loaded with N-1.
  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      HOLD:      return CNT_W'(RESET_HOLD_CYCLES - 1);
      WAIT_LOCK: return CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
      STABLE:    return CNT_W'(LOCK_STABLE_CYCLES - 1);
      default:   return '0;
    endcase
  endfunction

  logic               w_lock_s;
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt;
  logic               w_fail;

  logic r_pll_resetb, r_sys_reset_n, r_pll_ready, r_fault;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_fail      = 1'b0;

    case (r_state)
      HOLD: begin
        if (r_cnt == '0) w_state_nxt = WAIT_LOCK;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      WAIT_LOCK: begin
        // Lock is checked before expiry so a coincident lock wins.
        if (w_lock_s)          w_state_nxt = STABLE;
        else if (r_cnt == '0)  w_fail      = 1'b1;
        else                   w_cnt_nxt   = r_cnt - 1'b1;
      end
      STABLE: begin
        // Any low sample restarts the stability window without costing a retry.
        if (!w_lock_s)         w_cnt_nxt   = load_val(STABLE);
        else if (r_cnt == '0)  w_state_nxt = RUN;
        else                   w_cnt_nxt   = r_cnt - 1'b1;
      end
      RUN: begin
`ifdef PLL_SEQ_LOCK_MONITOR_EN
        if (!w_lock_s) w_fail = 1'b1;
`endif
      end
      FAULT: begin
      end
      default: w_state_nxt = HOLD;
    endcase

    if (w_fail) begin
      if (r_retry != RETRY_MAX) w_retry_nxt = r_retry + 1'b1;
      w_state_nxt = (w_retry_nxt == RETRY_MAX) ? FAULT : HOLD;
    end

    if (i_restart) begin
      w_state_nxt = HOLD;
      w_retry_nxt = '0;
    end

    // Reload on every entry, including a restart that re-enters HOLD from HOLD.
    if ((w_state_nxt != r_state) || i_restart) w_cnt_nxt = load_val(w_state_nxt);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HOLD;
      r_cnt   <= load_val(HOLD);
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register while still coming straight from flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pll_resetb  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_pll_ready   <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_pll_resetb  <= (w_state_nxt != HOLD) && (w_state_nxt != FAULT);
      r_sys_reset_n <= (w_state_nxt == RUN);
      r_pll_ready   <= (w_state_nxt == RUN);
      r_fault       <= (w_state_nxt == FAULT);
    end
  end

  assign o_pll_resetb  = r_pll_resetb;
  assign o_sys_reset_n = r_sys_reset_n;
  assign o_pll_ready   = r_pll_ready;
  assign o_fault       = r_fault;
  assign o_retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with HOLD=4, TIMEOUT=32, STABLE=8,
//   RETRIES=3. Inputs change 1 ns after a rising edge; outputs are sampled
//   at the same point. "tick N" below means the N-th rising edge after the
//   reset release, i.e. edge e(N-1).
module tb_pll_lock_sequencer;

  localparam int H = 4, T = 32, S = 8, R = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic       restart = 1'b0;
  logic       resetb, sys, ready, fault;
  logic [3:0] retry;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES   (H),
    .LOCK_TIMEOUT_CYCLES (T),
    .LOCK_STABLE_CYCLES  (S),
    .MAX_RETRIES         (R)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pll_lock    (lock),
    .i_restart     (restart),
    .o_pll_resetb  (resetb),
    .o_sys_reset_n (sys),
    .o_pll_ready   (ready),
    .o_fault       (fault),
    .o_retry_count (retry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {resetb, sys_reset_n, ready, fault, retry}
  function automatic logic [7:0] outv();
    return {resetb, sys, ready, fault, retry};
  endfunction

  task automatic do_reset(input logic lk);
    rst_n   = 1'b0;
    lock    = lk;
    restart = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Samples currently low, stepping a cycle per low sample.
  task automatic count_low(output int n);
    n = 0;
    while (resetb === 1'b0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (outv() !== 8'h00) begin
      n_err++;
      $display("FAIL reset_values: got %h need 00", outv());
    end
  endtask

  // Lock present from the start: 4 low samples, then WAIT (e3), STABLE (e4),
  // RUN (e12) -> 9 ticks after PLL_RESETB rises.
  task automatic test_lock_early();
    int n, k;
    logic apart;
    do_reset(1'b1);
    count_low(n);
    n_cmp++;
    if (n != H) begin n_err++; $display("FAIL hold_len_first: got %0d need %0d", n, H); end
    k = 0; apart = 1'b0;
    while (ready !== 1'b1 && k < 50) begin
      tick(); k++;
      if (sys !== ready) apart = 1'b1;
    end
    n_cmp++;
    if (k != 9) begin n_err++; $display("FAIL ready_early: got %0d ticks need 9", k); end
    n_cmp++;
    if (apart !== 1'b0 || sys !== 1'b1) begin
      n_err++; $display("FAIL sys_with_ready: apart=%b sys=%b need apart=0 sys=1", apart, sys);
    end
  endtask

  // Raw LOCK raised in WAIT_LOCK: 2 sync + 1 + 8 = 11 edges counting the
  // edge that first samples it.
  task automatic test_latency();
    int n, k;
    do_reset(1'b0);
    count_low(n);
    lock = 1'b1;
    k = 0;
    while (ready !== 1'b1 && k < 50) begin tick(); k++; end
    n_cmp++;
    if (k != 2 + 1 + S) begin n_err++; $display("FAIL lock_latency: got %0d need %0d", k, 2 + 1 + S); end
  endtask

  // Attempts of 4+32 cycles fail on ticks 36, 72, 108.
  task automatic test_timeout_fault();
    int n;
    logic [7:0] v35, v36, v39, v40, v72;
    do_reset(1'b0);
    for (int t = 1; t <= 108; t++) begin
      tick();
      if (t == 35) v35 = outv();
      if (t == 36) v36 = outv();
      if (t == 39) v39 = outv();
      if (t == 40) v40 = outv();
      if (t == 72) v72 = outv();
    end
    n_cmp++;
    if (v35 !== 8'h80) begin n_err++; $display("FAIL pre_timeout: got %h need 80", v35); end
    n_cmp++;
    if (v36 !== 8'h01) begin n_err++; $display("FAIL retry1_hold: got %h need 01", v36); end
    n_cmp++;
    if (v39 !== 8'h01 || v40 !== 8'h81) begin
      n_err++; $display("FAIL hold_len_retry: got %h/%h need 01/81", v39, v40);
    end
    n_cmp++;
    if (v72 !== 8'h02) begin n_err++; $display("FAIL retry2: got %h need 02", v72); end
    n_cmp++;
    if (outv() !== 8'h13) begin n_err++; $display("FAIL fault_entry: got %h need 13", outv()); end
    repeat (20) tick();
    n_cmp++;
    if (outv() !== 8'h13) begin n_err++; $display("FAIL fault_sticky: got %h need 13", outv()); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++;
    if (outv() !== 8'h00) begin n_err++; $display("FAIL restart_clear: got %h need 00", outv()); end
    count_low(n);
    n_cmp++;
    if (n != H) begin n_err++; $display("FAIL hold_len_restart: got %0d need %0d", n, H); end
  endtask

  // 5 good STABLE cycles, 1 glitch, then a full 8-cycle window: RUN on
  // tick 17 counting from the first LOCK sample.
  task automatic test_glitch();
    int n;
    do_reset(1'b0);
    count_low(n);
    lock = 1'b1;
    repeat (6) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    repeat (9) tick();
    n_cmp++;
    if (ready !== 1'b0 || retry !== 4'd0) begin
      n_err++; $display("FAIL glitch_hold_off: ready=%b retry=%0d need 0/0", ready, retry);
    end
    tick();
    n_cmp++;
    if (outv() !== 8'hE0) begin n_err++; $display("FAIL glitch_run: got %h need e0", outv()); end
  endtask

  // Called while in RUN with LOCK high.
  task automatic test_run_lock_loss();
    lock = 1'b0;
    repeat (3) tick();
    n_cmp++;
`ifdef PLL_SEQ_LOCK_MONITOR_EN
    if (outv() !== 8'h01) begin n_err++; $display("FAIL run_lock_loss: got %h need 01", outv()); end
`else
    if (outv() !== 8'hE0) begin n_err++; $display("FAIL run_lock_loss: got %h need e0", outv()); end
`endif
  endtask

  task automatic test_async_reset();
    int n, k;
    do_reset(1'b0);
    count_low(n);
    lock = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (outv() !== 8'h80) begin n_err++; $display("FAIL in_stable: got %h need 80", outv()); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outv() !== 8'h00) begin n_err++; $display("FAIL async_reset: got %h need 00", outv()); end
    do_reset(1'b1);
    count_low(n);
    n_cmp++;
    if (n != H) begin n_err++; $display("FAIL hold_after_reset: got %0d need %0d", n, H); end
    k = 0;
    while (ready !== 1'b1 && k < 50) begin tick(); k++; end
    n_cmp++;
    if (k != 9) begin n_err++; $display("FAIL ready_after_reset: got %0d need 9", k); end
  endtask

  // WAIT entered at e3, expiry edge e35 (tick 36). LOCK sampled at e33 gives
  // lock_s high exactly on the expiry cycle: STABLE at e35, RUN at tick 44.
  task automatic test_lock_on_timeout();
    do_reset(1'b0);
    repeat (33) tick();
    lock = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (outv() !== 8'h80) begin n_err++; $display("FAIL timeout_tie: got %h need 80", outv()); end
    repeat (7) tick();
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL tie_early: ready=%b need 0", ready); end
    tick();
    n_cmp++;
    if (outv() !== 8'hE0) begin n_err++; $display("FAIL tie_run: got %h need e0", outv()); end
  endtask

  initial begin
    test_reset();
    test_lock_early();
    test_latency();
    test_timeout_fault();
    test_glitch();
    test_run_lock_loss();
    test_async_reset();
    test_lock_on_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
